// File: rtl/trap_sequencer_pkg.sv
// Shared definitions for the trap sequencer: CSR addresses, mstatus bit
// positions, privilege encodings, the commit-stage exception pack and the
// sequencer state/kind enumerations.
package TrapPkg;

  localparam int unsigned TRAP_XLEN   = 64;
  localparam int unsigned TRAP_CSR_AW = 12;

  // CSR write addresses
  localparam logic [TRAP_CSR_AW-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [TRAP_CSR_AW-1:0] CSR_MEPC    = 12'h341;
  localparam logic [TRAP_CSR_AW-1:0] CSR_MCAUSE  = 12'h342;
  localparam logic [TRAP_CSR_AW-1:0] CSR_MTVAL   = 12'h343;
  localparam logic [TRAP_CSR_AW-1:0] CSR_SEPC    = 12'h141;
  localparam logic [TRAP_CSR_AW-1:0] CSR_SCAUSE  = 12'h142;
  localparam logic [TRAP_CSR_AW-1:0] CSR_STVAL   = 12'h143;

  // mstatus bit positions
  localparam int unsigned MS_SIE    = 1;
  localparam int unsigned MS_MIE    = 3;
  localparam int unsigned MS_SPIE   = 5;
  localparam int unsigned MS_MPIE   = 7;
  localparam int unsigned MS_SPP    = 8;
  localparam int unsigned MS_MPP_LO = 11;
  localparam int unsigned MS_MPP_HI = 12;

  // Privilege encodings
  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  // Exception pack handed over by the commit stage
  typedef struct packed {
    logic                 except;
    logic [TRAP_XLEN-1:0] epc;
    logic [TRAP_XLEN-1:0] ecause;
    logic [TRAP_XLEN-1:0] etval;
  } ExceptPack;

  typedef enum logic [2:0] {
    IDLE,
    T_EPC,
    T_CAUSE,
    T_TVAL,
    T_STAT,
    T_JMP,
    R_STAT,
    R_JMP
  } trap_state_t;

  // Which mstatus transformation the accepted request needs
  typedef enum logic [1:0] {
    K_TRAP_M,
    K_TRAP_S,
    K_MRET,
    K_SRET
  } trap_kind_t;

endpackage

// File: rtl/trap_sequencer_mstatus_update.sv
// Combinational mstatus rewrite for trap entry (M or S target) and for
// MRET/SRET. Bits not touched by the selected kind pass through unchanged.
module mstatus_update
  import TrapPkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [1:0]      priv_i,
  input  trap_kind_t      kind_i,
  output logic [XLEN-1:0] mstatus_o
);

  // Apply the interrupt-enable stack push/pop for the selected kind
  always_comb begin
    mstatus_o = mstatus_i;
    unique case (kind_i)
      K_TRAP_M: begin
        mstatus_o[MS_MPIE]             = mstatus_i[MS_MIE];
        mstatus_o[MS_MIE]              = 1'b0;
        mstatus_o[MS_MPP_HI:MS_MPP_LO] = priv_i;
      end
      K_TRAP_S: begin
        mstatus_o[MS_SPIE] = mstatus_i[MS_SIE];
        mstatus_o[MS_SIE]  = 1'b0;
        mstatus_o[MS_SPP]  = priv_i[0];
      end
      K_MRET: begin
        mstatus_o[MS_MIE]              = mstatus_i[MS_MPIE];
        mstatus_o[MS_MPIE]             = 1'b1;
        mstatus_o[MS_MPP_HI:MS_MPP_LO] = PRIV_U;
      end
      K_SRET: begin
        mstatus_o[MS_SIE]  = mstatus_i[MS_SPIE];
        mstatus_o[MS_SPIE] = 1'b1;
        mstatus_o[MS_SPP]  = 1'b0;
      end
      default: mstatus_o = mstatus_i;
    endcase
  end

endmodule

// File: rtl/trap_sequencer.sv
// Trap entry / return sequencer. Accepts one committed exception, MRET or
// SRET while idle, performs the delegation decision, issues the CSR writes
// one per cycle through the single write port, then redirects fetch and
// switches privilege.
module trap_sequencer
  import TrapPkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned CSR_AW = 12
) (
  input  logic              clk,
  input  logic              rstn,
  input  ExceptPack         except_i,
  input  logic              mret_i,
  input  logic              sret_i,
  output logic [1:0]        priv_o,
  input  logic [XLEN-1:0]   mstatus_i,
  input  logic [XLEN-1:0]   medeleg_i,
  input  logic [XLEN-1:0]   mtvec_i,
  input  logic [XLEN-1:0]   stvec_i,
  input  logic [XLEN-1:0]   mepc_i,
  input  logic [XLEN-1:0]   sepc_i,
  output logic              csr_we_o,
  output logic [CSR_AW-1:0] csr_addr_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  output logic              busy_o,
  output logic              flush_o,
  output logic              redirect_o,
  output logic [XLEN-1:0]   pc_o
);

  trap_state_t     state_q, state_d;
  trap_kind_t      kind_q, kind_d;
  logic [1:0]      priv_q, priv_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] ecause_q, ecause_d;
  logic [XLEN-1:0] etval_q, etval_d;
  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] mstatus_new;
  logic            deleg_s;
  logic            to_s;

  // New mstatus is derived from the values captured at acceptance
  mstatus_update #(
    .XLEN(XLEN)
  ) u_mstatus_update (
    .mstatus_i(mstatus_q),
    .priv_i   (priv_q),
    .kind_i   (kind_q),
    .mstatus_o(mstatus_new)
  );

  assign priv_o = priv_q;
  assign to_s   = (kind_q == K_TRAP_S);

  // Delegation decision evaluated against the live request in IDLE
  always_comb begin
    deleg_s = (priv_q != PRIV_M) & medeleg_i[except_i.ecause[5:0]] & ~except_i.ecause[XLEN-1];
  end

  // Next-state, capture and output decode
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    priv_d      = priv_q;
    epc_d       = epc_q;
    ecause_d    = ecause_q;
    etval_d     = etval_q;
    mstatus_d   = mstatus_q;
    csr_we_o    = 1'b0;
    csr_addr_o  = '0;
    csr_wdata_o = '0;
    busy_o      = (state_q != IDLE);
    flush_o     = 1'b0;
    redirect_o  = 1'b0;
    pc_o        = '0;

    unique case (state_q)
      IDLE: begin
        if (except_i.except | mret_i | sret_i) begin
          busy_o    = 1'b1;
          flush_o   = 1'b1;
          epc_d     = except_i.epc;
          ecause_d  = except_i.ecause;
          etval_d   = except_i.etval;
          mstatus_d = mstatus_i;
          // priv_q is already the privilege at acceptance and stays put
          // until the jump state, so it doubles as the captured privilege.
          if (except_i.except) begin
            kind_d  = deleg_s ? K_TRAP_S : K_TRAP_M;
            state_d = T_EPC;
          end else if (mret_i) begin
            kind_d  = K_MRET;
            state_d = R_STAT;
          end else begin
            kind_d  = K_SRET;
            state_d = R_STAT;
          end
        end
      end
      T_EPC: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = to_s ? CSR_SEPC : CSR_MEPC;
        csr_wdata_o = epc_q;
        state_d     = T_CAUSE;
      end
      T_CAUSE: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = to_s ? CSR_SCAUSE : CSR_MCAUSE;
        csr_wdata_o = ecause_q;
        state_d     = T_TVAL;
      end
      T_TVAL: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = to_s ? CSR_STVAL : CSR_MTVAL;
        csr_wdata_o = etval_q;
        state_d     = T_STAT;
      end
      T_STAT: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = CSR_MSTATUS;
        csr_wdata_o = mstatus_new;
        state_d     = T_JMP;
      end
      T_JMP: begin
        flush_o    = 1'b1;
        redirect_o = 1'b1;
        pc_o       = (to_s ? stvec_i : mtvec_i) & ~XLEN'(3);
        priv_d     = to_s ? PRIV_S : PRIV_M;
        state_d    = IDLE;
      end
      R_STAT: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = CSR_MSTATUS;
        csr_wdata_o = mstatus_new;
        state_d     = R_JMP;
      end
      R_JMP: begin
        flush_o    = 1'b1;
        redirect_o = 1'b1;
        if (kind_q == K_MRET) begin
          pc_o   = mepc_i;
          priv_d = mstatus_q[MS_MPP_HI:MS_MPP_LO];
        end else begin
          pc_o   = sepc_i;
          priv_d = {1'b0, mstatus_q[MS_SPP]};
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and capture registers; reset aborts any sequence in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      kind_q    <= K_TRAP_M;
      priv_q    <= PRIV_M;
      epc_q     <= '0;
      ecause_q  <= '0;
      etval_q   <= '0;
      mstatus_q <= '0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      priv_q    <= priv_d;
      epc_q     <= epc_d;
      ecause_q  <= ecause_d;
      etval_q   <= etval_d;
      mstatus_q <= mstatus_d;
    end
  end

endmodule
